// File: rtl/adder_arb.sv
// ---------------------------------------------------------------------------
// adder_arb
//   Round-robin arbiter in front of a single W-bit adder. One requester is
//   granted in IDLE, its operands are added in CALC, and the result is
//   presented in RESP until the downstream handshake completes.
//
//   Parameters
//     NREQ      number of requesters (2..8)
//     W         operand width
//   Ports
//     clk       clock, rising edge
//     rst       asynchronous reset, active high
//     req_valid per-requester operand valid               [NREQ]
//     req_ready per-requester accept strobe (one-hot/0)   [NREQ]
//     req_a     operand A, requester i at [i*W +: W]      [NREQ*W]
//     req_b     operand B, same packing                   [NREQ*W]
//     rsp_valid result valid
//     rsp_ready downstream accepts result
//     rsp_sum   A + B, MSB is carry                       [W+1]
//     rsp_id    requester that owns rsp_sum               [clog2(NREQ)]
//     busy      high whenever not IDLE
//     done_cnt  handshake counter, 8 bits, wraps (only with ADDER_ARB_CNT_EN)
//
//   Build option: define ADDER_ARB_CNT_EN to add the done_cnt output.
// ---------------------------------------------------------------------------
module adder_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_sum,
    output logic [IW-1:0]     rsp_id,
    output logic              busy
`ifdef ADDER_ARB_CNT_EN
    ,
    output logic [7:0]        done_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr;          // last requester served; search starts after it
    logic [IW-1:0] gnt_idx;
    logic          gnt_found;
    logic [IW-1:0] cand;
    logic [IW-1:0] g_r;
    logic [W-1:0]  a_r, b_r;
    logic          hs;

    assign hs = (state == RESP) && rsp_ready;

    // Round-robin search: ptr+1, ptr+2, ... wrapping, first valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Datapath: capture on grant, add in CALC, hold through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= IW'(NREQ - 1);
            g_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            rsp_sum <= '0;
            rsp_id  <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    g_r <= gnt_idx;
                    a_r <= req_a[int'(gnt_idx)*W +: W];
                    b_r <= req_b[int'(gnt_idx)*W +: W];
                end
                CALC: begin
                    rsp_sum <= {1'b0, a_r} + {1'b0, b_r};
                    rsp_id  <= g_r;
                end
                RESP: if (hs) ptr <= rsp_id;
                default: ;
            endcase
        end
    end

`ifdef ADDER_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     done_cnt <= 8'd0;
        else if (hs) done_cnt <= done_cnt + 8'd1;
    end
`else
    // No handshake counter in this build.
`endif

endmodule

// File: tb/tb_adder_arb.sv
module tb_adder_arb;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_sum;
    logic [1:0]        rsp_id;
    logic              busy;
`ifdef ADDER_ARB_CNT_EN
    logic [7:0]        done_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef ADDER_ARB_CNT_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    logic [W:0] exp_sum [4];

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        exp_sum[0] = 5'd9; exp_sum[1] = 5'd13; exp_sum[2] = 5'd17; exp_sum[3] = 5'd21;

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_sum",   32'(rsp_sum),   0);
        chk("rst_id",    32'(rsp_id),    0);
        chk("rst_busy",  32'(busy),      0);
`ifdef ADDER_ARB_CNT_EN
        chk("rst_cnt",   32'(done_cnt),  0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single request from 0: 3 + 5 = 8
        req_valid = 4'b0001; set_op(0, 4'd3, 4'd5);
        #1 chk("t1_ready", 32'(req_ready), 1);
        chk("t1_idle_busy", 32'(busy), 0);
        tick(); req_valid = '0;
        #1 chk("t1_calc_valid", 32'(rsp_valid), 0);
        chk("t1_calc_busy",  32'(busy), 1);
        chk("t1_calc_ready", 32'(req_ready), 0);
        tick();
        #1 chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_sum", 32'(rsp_sum), 8);
        chk("t1_id",  32'(rsp_id),  0);
        rsp_ready = 1'b1;
        tick();
        #1 chk("t1_done_valid", 32'(rsp_valid), 0);
        chk("t1_done_busy", 32'(busy), 0);

        // Carry out: 15 + 15 = 30 from requester 2
        req_valid = 4'b0100; set_op(2, 4'd15, 4'd15);
        #1 chk("t2_ready", 32'(req_ready), 4);
        tick(); req_valid = '0;
        tick();
        #1 chk("t2_valid", 32'(rsp_valid), 1);
        chk("t2_sum", 32'(rsp_sum), 30);
        chk("t2_id",  32'(rsp_id),  2);
        tick();
        #1 chk("t2_done_busy", 32'(busy), 0);

        // All requesting after reset: order 0,1,2,3,0, one per 3 cycles
        rst = 1'b1; #1 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i*3 + 2), 4'(i + 7));
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            #1 chk($sformatf("t3_ready%0d", j), 32'(req_ready), 32'(1 << (j % 4)));
            tick();
            #1 chk($sformatf("t3_calc%0d", j), 32'(rsp_valid), 0);
            tick();
            #1 chk($sformatf("t3_valid%0d", j), 32'(rsp_valid), 1);
            chk($sformatf("t3_id%0d", j),  32'(rsp_id),  32'(j % 4));
            chk($sformatf("t3_sum%0d", j), 32'(rsp_sum), 32'(exp_sum[j % 4]));
            tick();
        end

        // Back-pressure: hold RESP for 5 cycles, 7 + 9 = 16 from requester 1
        rsp_ready = 1'b0; req_valid = 4'b0010; set_op(1, 4'd7, 4'd9);
        #1 chk("t4_ready", 32'(req_ready), 2);
        tick(); req_valid = 4'hF;
        tick();
        #1 chk("t4_valid", 32'(rsp_valid), 1);
        chk("t4_sum", 32'(rsp_sum), 16);
        chk("t4_id",  32'(rsp_id),  1);
        for (int k = 0; k < 5; k++) begin
            tick();
            #1 chk($sformatf("t4_hold_valid%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("t4_hold_sum%0d", k),   32'(rsp_sum),   16);
            chk($sformatf("t4_hold_id%0d", k),    32'(rsp_id),    1);
            chk($sformatf("t4_hold_ready%0d", k), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        #1 chk("t4_hs_valid", 32'(rsp_valid), 1);
        tick();
        #1 chk("t4_after_valid", 32'(rsp_valid), 0);
        chk("t4_after_ready", 32'(req_ready), 4);
        req_valid = '0;

        // Reset during CALC discards result; next grant goes to 0
        req_valid = 4'b1000;
        #1 chk("t5_ready", 32'(req_ready), 8);
        tick(); req_valid = '0;
        #1 chk("t5_calc_busy", 32'(busy), 1);
        rst = 1'b1;
        #1 chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_sum", 32'(rsp_sum), 0);
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 chk($sformatf("t5_novalid%0d", k), 32'(rsp_valid), 0);
        end
        req_valid = 4'hF;
        #1 chk("t5_next_ready", 32'(req_ready), 1);
        req_valid = '0;

`ifdef ADDER_ARB_CNT_EN
        // 257 handshakes wrap the counter to 1
        rst = 1'b1; #1 rst = 1'b0;
        rsp_ready = 1'b1; req_valid = 4'b0001;
        for (int n = 0; n < 257; n++) begin
            tick(); tick(); tick();
        end
        req_valid = '0;
        #1 chk("t6_cnt", 32'(done_cnt), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
